// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Handshake and operand bus between register read, the ALU
//               issue stage and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32
);
    // Upstream side: decoded instruction plus operand data
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Downstream side: ALU operands and control
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      funct3;
    logic            is_sub_sra;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;

    // The issue stage itself
    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, op1, op2, funct3, is_sub_sra, rd, rd_we, illegal
    );

    // The environment driving and consuming the issue stage
    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, op1, op2, funct3, is_sub_sra, rd, rd_we, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : RV32I integer issue stage. Decodes OP / OP-IMM / LUI / AUIPC,
//               forms ALU operands and control, and buffers them in a
//               2-entry skid buffer (main M + skid S) with valid/ready on
//               both sides. in_ready depends only on registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_issue_if.slave  bus
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [2:0]      funct3;
        logic            is_sub_sra;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    entry_t r_main;
    entry_t r_skid;
    entry_t w_dec;

    logic w_accept;
    logic w_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clear;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_legal;
    logic            w_unused;

    // Instruction fields and immediates
    assign w_opcode = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_f7     = bus.instr[31:25];
    assign w_imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_u  = XLEN'({bus.instr[31:12], 12'b0});
    assign w_shamt  = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

    // rs1 index is resolved by register read; this stage only sees its data
    assign w_unused = ^bus.instr[19:15];

    // Decode the incoming instruction into an ALU entry
    always_comb begin
        w_dec            = '0;
        w_legal          = 1'b0;
        w_dec.op1        = '0;
        w_dec.op2        = '0;
        w_dec.funct3     = 3'b000;
        w_dec.is_sub_sra = 1'b0;
        unique case (w_opcode)
            c_OPC_OP: begin
                w_dec.op1        = bus.rs1_data;
                w_dec.op2        = bus.rs2_data;
                w_dec.funct3     = w_f3;
                w_dec.is_sub_sra = bus.instr[30];
                // Alternate funct7 only selects SUB (000) or SRA (101)
                w_legal = (w_f7 == c_F7_ZERO) ||
                          ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_OPC_OP_IMM: begin
                w_dec.op1    = bus.rs1_data;
                w_dec.funct3 = w_f3;
                if (w_f3 == 3'b001) begin
                    w_dec.op2 = w_shamt;
                    w_legal   = (w_f7 == c_F7_ZERO);
                end else if (w_f3 == 3'b101) begin
                    w_dec.op2        = w_shamt;
                    w_dec.is_sub_sra = bus.instr[30];
                    w_legal          = (w_f7 == c_F7_ZERO) || (w_f7 == c_F7_ALT);
                end else begin
                    w_dec.op2 = w_imm_i;
                    w_legal   = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_dec.op2 = w_imm_u;
                w_legal   = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_dec.op1 = bus.pc;
                w_dec.op2 = w_imm_u;
                w_legal   = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (w_legal) begin
            w_dec.rd      = bus.instr[11:7];
            w_dec.rd_we   = 1'b1;
            w_dec.illegal = 1'b0;
        end else begin
            // Illegal entries carry no operands, only the illegal flag
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
    end

    // Handshake qualifiers; in_ready comes straight from the state register
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_fire        = bus.out_valid & bus.out_ready;

    // Buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and data-movement selection; flush wins over accept/fire
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear          = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_clear     = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    // Main and skid entry storage
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    // All issued fields come from the main register
    assign bus.op1        = r_main.op1;
    assign bus.op2        = r_main.op2;
    assign bus.funct3     = r_main.funct3;
    assign bus.is_sub_sra = r_main.is_sub_sra;
    assign bus.rd         = r_main.rd;
    assign bus.rd_we      = r_main.rd_we;
    assign bus.illegal    = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue: directed steps plus a
//               queue scoreboard filled on accept and drained on fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  funct3;
        logic        is_sub_sra;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_cur = '0;
    exp_t sb_q[$];

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference decode written directly from the RV32I encodings
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t       e  = '0;
        logic       ok = 1'b0;
        logic [6:0] f7 = i[31:25];
        logic [2:0] f3 = i[14:12];
        case (i[6:0])
            7'h33: begin
                e.op1 = a; e.op2 = b; e.funct3 = f3; e.is_sub_sra = i[30];
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h13: begin
                e.op1 = a; e.funct3 = f3;
                if (f3 == 3'd1) begin
                    e.op2 = {27'd0, i[24:20]}; ok = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    e.op2 = {27'd0, i[24:20]}; e.is_sub_sra = i[30];
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    e.op2 = {{20{i[31]}}, i[31:20]}; ok = 1'b1;
                end
            end
            7'h37: begin e.op2 = {i[31:12], 12'h000}; ok = 1'b1; end
            7'h17: begin e.op1 = p; e.op2 = {i[31:12], 12'h000}; ok = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            e.rd = i[11:7]; e.rd_we = 1'b1;
        end else begin
            e = '0; e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.op1 = bus.op1; o.op2 = bus.op2; o.funct3 = bus.funct3;
        o.is_sub_sra = bus.is_sub_sra; o.rd = bus.rd; o.rd_we = bus.rd_we;
        o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        bus.instr = i; bus.pc = p; bus.rs1_data = a; bus.rs2_data = b;
        bus.in_valid = 1'b1;
        exp_cur = model(i, p, a, b);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scoreboard: compare on fire, record on accept, drop everything on rst/flush
    always @(negedge clk) begin
        if (rst || bus.flush) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                assert (sb_q.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected_issue: observed %h expected none", observed());
                end
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    tests++;
                    assert (observed() === e) else begin
                        fails++;
                        $error("FAIL sb_entry: observed %h expected %h", observed(), e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(exp_cur);
            end
        end
    end

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_op1",       bus.op1,            32'd0);
        chk("rst_illegal",   32'(bus.illegal),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Decode stream at full throughput
        bus.out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);            // ADD x3,x1,x2
        chk("add_valid",  32'(bus.out_valid),  32'd1);
        chk("add_op1",    bus.op1,             32'd5);
        chk("add_op2",    bus.op2,             32'd7);
        chk("add_funct3", 32'(bus.funct3),     32'd0);
        chk("add_sub",    32'(bus.is_sub_sra), 32'd0);
        chk("add_rd",     32'(bus.rd),         32'd3);
        chk("add_rd_we",  32'(bus.rd_we),      32'd1);
        chk("add_illegal",32'(bus.illegal),    32'd0);
        send(32'h402081B3, 32'h0, 32'd5, 32'd7);            // SUB
        chk("sub_sub",    32'(bus.is_sub_sra), 32'd1);
        send(32'h40335293, 32'h0, 32'h80000000, 32'd9);     // SRAI x5,x6,3
        chk("srai_op2",   bus.op2,             32'd3);
        chk("srai_funct3",32'(bus.funct3),     32'd5);
        chk("srai_sub",   32'(bus.is_sub_sra), 32'd1);
        chk("srai_rd",    32'(bus.rd),         32'd5);
        send(32'hFFF08093, 32'h0, 32'd1, 32'd0);            // ADDI x1,x1,-1
        chk("addi_op2",   bus.op2,             32'hFFFFFFFF);
        chk("addi_sub",   32'(bus.is_sub_sra), 32'd0);
        send(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF);      // LUI
        chk("lui_op1",    bus.op1,             32'd0);
        chk("lui_op2",    bus.op2,             32'h12345000);
        send(32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF);    // AUIPC
        chk("auipc_op1",  bus.op1,             32'h100);
        chk("auipc_op2",  bus.op2,             32'h12345000);
        send(32'h4020C1B3, 32'h0, 32'd3, 32'd4);            // XOR with alt funct7
        chk("xor7_illegal", 32'(bus.illegal),  32'd1);
        chk("xor7_rd_we",   32'(bus.rd_we),    32'd0);
        chk("xor7_op1",     bus.op1,           32'd0);
        chk("xor7_op2",     bus.op2,           32'd0);
        send(32'h0000007F, 32'h0, 32'd3, 32'd4);            // unknown opcode
        chk("opc7f_illegal", 32'(bus.illegal), 32'd1);
        idle();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: A in M, B in S, C held off
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);            // A
        send(32'h402081B3, 32'h0, 32'd10, 32'd3);           // B
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_op1_A",    bus.op1,           32'd1);
        bus.instr = 32'h0F00E213; bus.rs1_data = 32'h55; bus.rs2_data = 32'h0;
        exp_cur = model(32'h0F00E213, 32'h0, 32'h55, 32'h0); // C: ORI x4,x1,0xF0
        repeat (3) @(posedge clk);
        #1;
        chk("stall_op1", bus.op1,           32'd1);
        chk("stall_op2", bus.op2,           32'd2);
        chk("stall_rd",  32'(bus.rd),       32'd3);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("order_B_op1", bus.op1, 32'd10);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("order_C_op1", bus.op1, 32'h55);
        chk("order_C_op2", bus.op2, 32'hF0);
        @(posedge clk); #1;
        chk("order_done_valid", 32'(bus.out_valid), 32'd0);
        chk("order_sb_empty",   32'(sb_q.size()),   32'd0);

        // Flush while FULL with a same-cycle input
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);
        send(32'h402081B3, 32'h0, 32'd10, 32'd3);
        bus.instr = 32'h123450B7; exp_cur = model(32'h123450B7, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid",    32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_issue", 32'(bus.out_valid), 32'd0);

        // Reset while FULL with a same-cycle input
        bus.out_ready = 1'b0;
        send(32'h40335293, 32'h0, 32'h80000000, 32'd0);
        send(32'hFFF08093, 32'h0, 32'd7, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_valid",    32'(bus.out_valid),  32'd0);
        chk("rst2_in_ready", 32'(bus.in_ready),   32'd1);
        chk("rst2_op1",      bus.op1,             32'd0);
        chk("rst2_op2",      bus.op2,             32'd0);
        chk("rst2_funct3",   32'(bus.funct3),     32'd0);
        chk("rst2_sub",      32'(bus.is_sub_sra), 32'd0);
        chk("rst2_rd",       32'(bus.rd),         32'd0);
        chk("rst2_rd_we",    32'(bus.rd_we),      32'd0);
        chk("rst2_illegal",  32'(bus.illegal),    32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // Recovery after reset
        bus.out_ready = 1'b1;
        send(32'hFFF08093, 32'h0, 32'd9, 32'd0);
        chk("post_rst_op1", bus.op1, 32'd9);
        idle();
        idle();
        chk("end_valid",    32'(bus.out_valid), 32'd0);
        chk("end_sb_empty", 32'(sb_q.size()),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
